light_safety_monitor: RTL and testbench
=======================================

# light_safety_monitor

Safety monitor that sits directly downstream of the two-road traffic light controller. It consumes the controller's per-direction light codes for direction A and direction B, and checks every cycle for illegal encodings, conflicting greens, illegal sequences and dwell-time violations. Legal codes pass through to the lamp drivers with 1-cycle latency. On any violation it latches a fault code and forces both directions to flashing red until software clears it. A violating code never reaches the outputs.

## Interface
- MIN_GREEN, 5: minimum cycles a green must be held before going yellow.
- YEL_TIME, 1: exact cycles a yellow must be held.
- MIN_CLEAR, 1: minimum consecutive all-red cycles before either direction goes green.
- FLASH_HALF, 2: cycles per on/off half-period of fault flashing.
- CNT_W, 4: width of the dwell and all-red counters. They saturate at 2^CNT_W-1.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- a_in  in  3  direction A light from controller; 001 green, 010 yellow, 100 red.
- b_in  in  3  direction B light, same encoding.
- fault_clr  in  1  synchronous fault clear; ignored when fault=0.
- a_out  out  3  direction A lamp drive.
- b_out  out  3  direction B lamp drive.
- fault  out  1  latched fault flag.
- fault_code  out  3  first detected violation; 0 = none.

## Operation
- State registers:
  - s_a, s_b: last accepted codes.
  - dw_a, dw_b: consecutive cycles the s value has been held, including the current cycle.
  - ar: consecutive cycles in which s_a and s_b are both red.
  - armed, fault, fault_code, flash counter, flash phase.
- Checks run combinationally on a_in/b_in against s/dw/ar. Priority is lowest code first; A is checked before B.
  - Code 1: a_in or b_in is not one of 001/010/100.
  - Code 2: a_in and b_in are both non-red.
  - Code 3 (armed only): illegal change. Legal changes are only G→Y, Y→R and R→G; holding the same value is legal.
  - Code 4 (armed only): G→Y with dw < MIN_GREEN.
  - Code 5 (armed only): Y→R with dw ≠ YEL_TIME, or Y held with dw ≥ YEL_TIME (overstay).
  - Code 6 (armed only): R→G with ar < MIN_CLEAR.
- Clock edge, fault=0, no violation:
  - s ← in.
  - dw ← (in==s && armed) ? sat(dw+1) : 1.
  - ar ← both in red ? ((both s red && armed) ? sat(ar+1) : 1) : 0.
  - armed ← 1.
- Clock edge, fault=0, violation:
  - fault ← 1, fault_code ← code.
  - s, dw and ar hold their last good values.
  - Flash counter ← 0, phase ← on.
- While fault=1:
  - No checks run; fault_code is frozen.
  - a_out = b_out = 100 while phase is on, 000 while phase is off.
  - Phase toggles every FLASH_HALF cycles.
- While fault=0: a_out = s_a, b_out = s_b.
- fault_clr=1 while fault=1: at the next edge fault ← 0, fault_code ← 0, armed ← 0. The sample taken at that same edge is not captured. Monitoring resumes at the following edge as a first sample after reset: codes 1 and 2 only, then s/dw/ar initialise.
- First sample after reset or clear (armed=0): only codes 1 and 2 are checked.

## Timing
- Reset values:
  - s_a = s_b = 100; dw = ar = 0; armed = 0.
  - fault = 0, fault_code = 000.
  - a_out = b_out = 100.
- Latency: a_in/b_in to a_out/b_out is 1 cycle.
- A violation present before edge N asserts fault at edge N. From edge N, outputs show flash-on (100/100) and never show the violating code.
- Flash sequence from fault edge with FLASH_HALF=2: 100, 100, 000, 000, 100, … on both outputs.
- Counter saturation: dw and ar stop at 2^CNT_W-1 and do not wrap. A long green stays legal; a long yellow has already faulted with code 5.
- Simultaneous violations on A and B: the lowest code is reported.
- Reset asserted mid-fault or mid-flash: everything returns to reset values immediately.
- With the controller's nominal sequence, the monitor is fault-free: green 5, yellow 1, all-red 1 per direction, alternating.

## Test plan
- Nominal run: reset, then drive the legal cycle G5/Y1/R1 alternating for 200 cycles → fault=0 throughout; a_out/b_out equal a_in/b_in delayed exactly 1 cycle.
- Conflict: a_in=001 and b_in=001 at edge N → fault=1 and fault_code=2 at N. Outputs 100,100,000,000,100 on both from N.
- Short green: A green for 3 cycles, then 010 → fault_code=4 at the yellow edge; a_out never shows 010.
- Yellow overstay: A yellow for 2 cycles with YEL_TIME=1 → fault_code=5 at the second yellow edge. Separately, A 001→100 → code 3. Separately, b_in=011 → code 1.
- Clear and resume: while faulted, pulse fault_clr for 1 cycle → fault=0 and fault_code=0 next edge; the legal sequence continues with no fault and no code 6 on the first green.
- Reset mid-flash: assert rst asynchronously during flash-off → a_out=b_out=100 and fault=0 immediately. After release, the legal sequence runs with no fault.

Source files
------------

// File: rtl/light_safety_monitor.sv
// rtl/light_safety_monitor.sv - traffic light safety monitor with fault latch and flashing red
//
// Checks the controller's per-direction light codes every cycle for illegal
// encodings, conflicting greens, illegal sequences and dwell-time violations.
// Legal codes reach the lamp drivers one cycle later; a violation latches a
// fault code and flashes red on both directions until software clears it.
//
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   a_in, b_in  light codes from the controller (001 green, 010 yellow, 100 red)
//   fault_clr   synchronous fault clear, ignored while no fault is latched
//   a_out,b_out lamp drive
//   fault       latched fault flag
//   fault_code  first detected violation, 0 when none
module light_safety_monitor #(
  parameter int MIN_GREEN  = 5,
  parameter int YEL_TIME   = 1,
  parameter int MIN_CLEAR  = 1,
  parameter int FLASH_HALF = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a_in,
  input  logic [2:0] b_in,
  input  logic       fault_clr,
  output logic [2:0] a_out,
  output logic [2:0] b_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MG      = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] YT      = CNT_W'(YEL_TIME);
  localparam logic [CNT_W-1:0] MC      = CNT_W'(MIN_CLEAR);

  localparam int FW = $clog2(FLASH_HALF) + 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  logic [2:0]       s_a, s_b;
  logic [CNT_W-1:0] dw_a, dw_b, ar;
  logic             armed;
  logic [FW-1:0]    flash_cnt;
  logic             flash_on;

  logic [2:0] code_a, code_b, viol;

  function automatic logic is_valid(input logic [2:0] v);
    return (v == GRN) || (v == YEL) || (v == RED);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Sequence/dwell check for one direction; only meaningful on an armed,
  // already-valid sample. Each transition can raise at most one code.
  function automatic logic [2:0] dir_code(input logic [2:0] in,
                                          input logic [2:0] s,
                                          input logic [CNT_W-1:0] dw,
                                          input logic [CNT_W-1:0] arv);
    logic [2:0] c;
    c = 3'd0;
    if (in != s) begin
      if (s == GRN && in == YEL) begin
        if (dw < MG) c = 3'd4;
      end else if (s == YEL && in == RED) begin
        if (dw != YT) c = 3'd5;
      end else if (s == RED && in == GRN) begin
        if (arv < MC) c = 3'd6;
      end else begin
        c = 3'd3;
      end
    end else if (s == YEL && dw >= YT) begin
      c = 3'd5;  // yellow overstay
    end
    return c;
  endfunction

  always_comb begin
    code_a = dir_code(a_in, s_a, dw_a, ar);
    code_b = dir_code(b_in, s_b, dw_b, ar);
    viol   = 3'd0;
    if (!is_valid(a_in) || !is_valid(b_in)) begin
      viol = 3'd1;
    end else if (a_in != RED && b_in != RED) begin
      viol = 3'd2;
    end else if (armed) begin
      // lowest nonzero code wins; A takes ties
      if (code_a != 3'd0 && (code_b == 3'd0 || code_a <= code_b)) viol = code_a;
      else viol = code_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a        <= RED;
      s_b        <= RED;
      dw_a       <= '0;
      dw_b       <= '0;
      ar         <= '0;
      armed      <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      flash_cnt  <= '0;
      flash_on   <= 1'b1;
    end else if (fault) begin
      if (fault_clr) begin
        // the sample at this edge is dropped; the next one is a fresh start
        fault      <= 1'b0;
        fault_code <= 3'd0;
        armed      <= 1'b0;
      end else if (flash_cnt == FLASH_LAST) begin
        flash_cnt <= '0;
        flash_on  <= ~flash_on;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end else if (viol != 3'd0) begin
      fault      <= 1'b1;
      fault_code <= viol;
      flash_cnt  <= '0;
      flash_on   <= 1'b1;
    end else begin
      s_a   <= a_in;
      s_b   <= b_in;
      dw_a  <= (a_in == s_a && armed) ? sat_inc(dw_a) : CNT_W'(1);
      dw_b  <= (b_in == s_b && armed) ? sat_inc(dw_b) : CNT_W'(1);
      if (a_in == RED && b_in == RED)
        ar <= (s_a == RED && s_b == RED && armed) ? sat_inc(ar) : CNT_W'(1);
      else
        ar <= '0;
      armed <= 1'b1;
    end
  end

  always_comb begin
    a_out = s_a;
    b_out = s_b;
    if (fault) begin
      a_out = flash_on ? RED : 3'b000;
      b_out = flash_on ? RED : 3'b000;
    end
  end

endmodule

// File: tb/tb_light_safety_monitor.sv
// tb/tb_light_safety_monitor.sv - directed self-checking bench for light_safety_monitor
module tb_light_safety_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk;
  logic       rst;
  logic [2:0] a_in, b_in;
  logic       fault_clr;
  logic [2:0] a_out, b_out;
  logic       fault;
  logic [2:0] fault_code;

  int total = 0;
  int bad   = 0;

  light_safety_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .fault_clr (fault_clr),
    .a_out     (a_out),
    .b_out     (b_out),
    .fault     (fault),
    .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // apply inputs, then sample 1 time unit after the next rising edge
  task automatic cyc(input logic [2:0] a, input logic [2:0] b);
    a_in = a;
    b_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in = R;
    b_in = R;
    fault_clr = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  // nominal controller cycle: A G5 Y1, all-red 1, B G5 Y1, all-red 1
  function automatic logic [5:0] nom(input int p);
    if (p < 5)       return {G, R};
    else if (p == 5) return {Y, R};
    else if (p == 6) return {R, R};
    else if (p < 12) return {R, G};
    else if (p == 12) return {R, Y};
    else             return {R, R};
  endfunction

  task automatic run_seq(input int n, input string tag);
    logic [2:0] pa, pb;
    logic [5:0] v;
    pa = a_in;
    pb = b_in;
    for (int i = 0; i < n; i++) begin
      v = nom(i % 14);
      a_in = v[5:3];
      b_in = v[2:0];
      #1;
      chk({tag, "_a_hold"}, a_out, pa);
      chk({tag, "_b_hold"}, b_out, pb);
      @(posedge clk);
      #1;
      chk({tag, "_fault"}, {2'b0, fault}, 3'd0);
      chk({tag, "_a_out"}, a_out, v[5:3]);
      chk({tag, "_b_out"}, b_out, v[2:0]);
      pa = v[5:3];
      pb = v[2:0];
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in = R;
    b_in = R;
    fault_clr = 1'b0;
    #1;
    chk("rst_a_out", a_out, R);
    chk("rst_b_out", b_out, R);
    chk("rst_fault", {2'b0, fault}, 3'd0);
    chk("rst_code", fault_code, 3'd0);
    @(posedge clk);
    #1;
    chk("rst_held_a_out", a_out, R);
    rst = 1'b0;

    // nominal run
    cyc(R, R);
    run_seq(200, "nominal");

    // conflicting greens, then flash pattern
    do_reset();
    cyc(G, G);
    chk("conf_fault", {2'b0, fault}, 3'd1);
    chk("conf_code", fault_code, 3'd2);
    chk("conf_a0", a_out, R);
    chk("conf_b0", b_out, R);
    cyc(R, R); chk("flash1_a", a_out, R);      chk("flash1_b", b_out, R);
    cyc(R, R); chk("flash2_a", a_out, 3'b000); chk("flash2_b", b_out, 3'b000);
    cyc(R, R); chk("flash3_a", a_out, 3'b000); chk("flash3_b", b_out, 3'b000);
    cyc(R, R); chk("flash4_a", a_out, R);      chk("flash4_b", b_out, R);
    chk("conf_code_frozen", fault_code, 3'd2);

    // short green
    do_reset();
    cyc(G, R); cyc(G, R); cyc(G, R);
    chk("short_pre_a", a_out, G);
    cyc(Y, R);
    chk("short_code", fault_code, 3'd4);
    chk("short_a_out", a_out, R);

    // yellow overstay
    do_reset();
    for (int i = 0; i < 5; i++) cyc(G, R);
    cyc(Y, R);
    chk("ovr_y1_fault", {2'b0, fault}, 3'd0);
    chk("ovr_y1_a", a_out, Y);
    cyc(Y, R);
    chk("ovr_code", fault_code, 3'd5);
    chk("ovr_a_out", a_out, R);

    // green straight to red
    do_reset();
    cyc(G, R);
    cyc(R, R);
    chk("g2r_code", fault_code, 3'd3);

    // invalid encoding together with a conflict: lowest code wins
    do_reset();
    cyc(3'b011, G);
    chk("inv_conf_code", fault_code, 3'd1);

    // long green saturates and stays legal
    do_reset();
    for (int i = 0; i < 20; i++) cyc(G, R);
    chk("long_g_fault", {2'b0, fault}, 3'd0);
    cyc(Y, R);
    chk("long_g_y_fault", {2'b0, fault}, 3'd0);
    chk("long_g_y_a", a_out, Y);
    cyc(R, R);
    chk("long_g_r_fault", {2'b0, fault}, 3'd0);

    // invalid B, then clear and resume
    do_reset();
    cyc(R, 3'b011);
    chk("inv_code", fault_code, 3'd1);
    cyc(R, R);
    fault_clr = 1'b1;
    cyc(G, G);  // dropped sample
    fault_clr = 1'b0;
    chk("clr_fault", {2'b0, fault}, 3'd0);
    chk("clr_code", fault_code, 3'd0);
    chk("clr_a_out", a_out, R);
    cyc(R, R);
    run_seq(28, "resume");

    // reset during flash-off
    do_reset();
    cyc(G, G);
    cyc(R, R);
    cyc(R, R);
    chk("midflash_off", a_out, 3'b000);
    rst = 1'b1;
    #1;
    chk("midflash_rst_a", a_out, R);
    chk("midflash_rst_b", b_out, R);
    chk("midflash_rst_fault", {2'b0, fault}, 3'd0);
    chk("midflash_rst_code", fault_code, 3'd0);
    #2;
    rst = 1'b0;
    cyc(R, R);
    run_seq(28, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
